// File: rtl/spi_ram_master.sv
// -----------------------------------------------------------------------------
// spi_ram_master
//
// Cycle-based SPI master for the SPI slave + single-port RAM wrapper. It runs
// on the shared system clock, so every SPI "bit time" is one clk cycle.
//
// A host command is {op[1:0], data[7:0]}. The master turns it into a 10-bit
// frame and shifts it out MSB first. Opcodes:
//   00 write address, 01 write data, 10 read address, 11 read data.
// For a read-data frame (op 11), the master waits RD_LATENCY cycles after the
// last MOSI bit. It then samples 8 MISO bits, MSB first, and returns that byte
// to the host.
//
// Frame timeline (SS_n low for the whole frame):
//   SEL (START_GAP) -> SHIFT_TX (10) -> [WAIT_RD (RD_LATENCY) -> SHIFT_RX (8)]
//   -> END (END_GAP, SS_n high) -> IDLE
//
// Optional feature (macro SPI_RAM_MASTER_STATS_EN):
//   Adds output frame_cnt[15:0]. It counts completed frames (entries into
//   END) and wraps at 16'hFFFF.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  host command valid
//   cmd_ready  high only in IDLE; a command transfers on cmd_valid && cmd_ready
//   cmd_op     2-bit opcode
//   cmd_data   8-bit address/data payload
//   rsp_valid  one-cycle pulse when a read-data byte is captured
//   rsp_data   last captured byte, held until the next capture
//   busy       high whenever not in IDLE
//   SS_n       slave select, active low (registered)
//   MOSI       serial data to the slave (registered)
//   MISO       serial data from the slave
//   frame_cnt  (stats build only) completed-frame counter
// -----------------------------------------------------------------------------
module spi_ram_master #(
  parameter int unsigned START_GAP  = 1,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned END_GAP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
`ifdef SPI_RAM_MASTER_STATS_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEL      = 3'd1,
    ST_SHIFT_TX = 3'd2,
    ST_WAIT_RD  = 3'd3,
    ST_SHIFT_RX = 3'd4,
    ST_END      = 3'd5
  } state_t;

  // Last-cycle values for each phase. The phase counters are 4 bits wide,
  // and each phase ends on an exact compare.
  localparam logic [3:0] START_LAST = 4'(START_GAP - 1);
  localparam logic [3:0] TX_LAST    = 4'd9;
  localparam logic [3:0] RD_LAST    = 4'(RD_LATENCY - 1);
  localparam logic [3:0] RX_LAST    = 4'd7;
  localparam logic [3:0] END_LAST   = 4'(END_GAP - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [9:0]  frame_r;      // shifts left; bit 9 is always the next MOSI bit
  logic        rd_op_r;      // frame in flight is a read-data frame
  logic [6:0]  rx_sr_r;      // first 7 received bits; the 8th goes straight out
  logic        ss_n_r;
  logic        mosi_r;
  logic        cmd_ready_r;
  logic        busy_r;
  logic        rsp_valid_r;
  logic [7:0]  rsp_data_r;

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign SS_n      = ss_n_r;
  assign MOSI      = mosi_r;

  // Frame sequencer: state, phase counter, shift registers and registered pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      frame_r     <= 10'd0;
      rd_op_r     <= 1'b0;
      rx_sr_r     <= 7'd0;
      ss_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            frame_r     <= {cmd_op, cmd_data};
            rd_op_r     <= (cmd_op == 2'b11);
            cnt_r       <= 4'd0;
            ss_n_r      <= 1'b0;
            mosi_r      <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (cnt_r == START_LAST) begin
            cnt_r   <= 4'd0;
            mosi_r  <= frame_r[9];
            frame_r <= {frame_r[8:0], 1'b0};
            state_r <= ST_SHIFT_TX;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_SHIFT_TX: begin
          if (cnt_r == TX_LAST) begin
            cnt_r  <= 4'd0;
            mosi_r <= 1'b0;
            if (rd_op_r) begin
              state_r <= ST_WAIT_RD;
            end else begin
              ss_n_r  <= 1'b1;
              state_r <= ST_END;
            end
          end else begin
            cnt_r   <= cnt_r + 4'd1;
            mosi_r  <= frame_r[9];
            frame_r <= {frame_r[8:0], 1'b0};
          end
        end
        ST_WAIT_RD: begin
          if (cnt_r == RD_LAST) begin
            cnt_r   <= 4'd0;
            state_r <= ST_SHIFT_RX;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_SHIFT_RX: begin
          rx_sr_r <= {rx_sr_r[5:0], MISO};
          if (cnt_r == RX_LAST) begin
            // The 8th sample completes the byte in the same edge that
            // releases SS_n, so rsp_valid lines up with the first END cycle.
            rsp_data_r  <= {rx_sr_r, MISO};
            rsp_valid_r <= 1'b1;
            cnt_r       <= 4'd0;
            ss_n_r      <= 1'b1;
            state_r     <= ST_END;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_END: begin
          if (cnt_r == END_LAST) begin
            cnt_r       <= 4'd0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          // An unreachable encoding drops the bus and returns to IDLE.
          cnt_r       <= 4'd0;
          ss_n_r      <= 1'b1;
          mosi_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_RAM_MASTER_STATS_EN
  logic        end_entry_s;
  logic [15:0] frame_cnt_r;

  assign frame_cnt = frame_cnt_r;

  // Detect the edge that moves the sequencer into END (frame completed).
  always_comb begin
    end_entry_s = 1'b0;
    if (state_r == ST_SHIFT_TX) begin
      end_entry_s = (cnt_r == TX_LAST) && !rd_op_r;
    end else if (state_r == ST_SHIFT_RX) begin
      end_entry_s = (cnt_r == RX_LAST);
    end else begin
      end_entry_s = 1'b0;
    end
  end

  // Completed-frame counter. It wraps naturally, and reset takes priority,
  // so an aborted frame is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 16'd0;
    end else if (end_entry_s) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_ram_master.sv
module tb_spi_ram_master;

  localparam int S = 1;
  localparam int R = 2;
  localparam int E = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       ss_n;
  logic       mosi;
  logic       miso = 1'b0;
`ifdef SPI_RAM_MASTER_STATS_EN
  logic [15:0] frame_cnt;
`endif

  spi_ram_master #(.START_GAP(S), .RD_LATENCY(R), .END_GAP(E)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (ss_n),
    .MOSI      (mosi),
    .MISO      (miso)
`ifdef SPI_RAM_MASTER_STATS_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Scoreboard: expected frames (bits + SS_n-low length) and read responses.
  logic [9:0] frame_q[$];
  int         len_q[$];
  logic [7:0] rsp_q[$];

  // Behavioural slave + RAM, fed only by what the DUT put on MOSI.
  logic [7:0] ram [256];
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] rd_addr = 8'h00;

  // Monitor / slave model: samples on negedge and drives MISO for the next posedge.
  task automatic monitor();
    bit         in_frame = 1'b0;
    bit         prev_ok = 1'b0;
    int         idx = 0;
    int         hi_cnt = 0;
    int         rx0 = S + 10 + R;
    logic [9:0] cap = 10'd0;
    logic [9:0] ef;
    int         el;
    logic [7:0] er;
    logic [7:0] byte_v;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_frame = 1'b0;
        prev_ok  = 1'b0;
        idx      = 0;
        miso     = 1'b0;
      end else begin
        if (!ss_n) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            idx = 0;
            cap = 10'd0;
            if (prev_ok) begin
              checks++;
              if (hi_cnt < E + 1) begin
                errors++;
                $display("FAIL end_gap: SS_n high %0d cycles, required >= %0d", hi_cnt, E + 1);
              end
            end
          end
          checks++;
          if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL in_frame_flags: cmd_ready=%b busy=%b at frame cycle %0d, required 0/1", cmd_ready, busy, idx);
          end
          if (idx >= S && idx < S + 10) begin
            cap = {cap[8:0], mosi};
          end else begin
            checks++;
            if (mosi !== 1'b0) begin
              errors++;
              $display("FAIL mosi_idle: MOSI=%b at frame cycle %0d, required 0", mosi, idx);
            end
          end
          if (cap[9:8] == 2'b11 && idx >= rx0 && idx < rx0 + 8) begin
            byte_v = ram[rd_addr];
            miso = byte_v[7 - (idx - rx0)];
          end else begin
            miso = 1'b0;
          end
          idx++;
        end else begin
          miso = 1'b0;
          if (in_frame) begin
            in_frame = 1'b0;
            checks++;
            if (frame_q.size() == 0) begin
              errors++;
              $display("FAIL frame_unexpected: got frame %b of %0d cycles, required none", cap, idx);
            end else begin
              ef = frame_q.pop_front();
              el = len_q.pop_front();
              if (cap !== ef || idx != el) begin
                errors++;
                $display("FAIL frame: bits=%b len=%0d, required bits=%b len=%0d", cap, idx, ef, el);
              end
            end
            case (cap[9:8])
              2'b00:   wr_addr = cap[7:0];
              2'b01:   ram[wr_addr] = cap[7:0];
              2'b10:   rd_addr = cap[7:0];
              default: ;
            endcase
            prev_ok = 1'b1;
            hi_cnt = 0;
          end
          hi_cnt++;
          checks++;
          if (mosi !== 1'b0) begin
            errors++;
            $display("FAIL mosi_deselected: MOSI=%b with SS_n high, required 0", mosi);
          end
        end
        if (rsp_valid) begin
          checks++;
          if (rsp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid=1 rsp_data=%h, required no response", rsp_data);
          end else begin
            er = rsp_q.pop_front();
            if (rsp_data !== er) begin
              errors++;
              $display("FAIL rsp_data: got %h, required %h", rsp_data, er);
            end
          end
        end
      end
    end
  endtask

  // Present a command, hold it until accepted, push expectations, then scramble cmd_*.
  task automatic send(input logic [1:0] op, input logic [7:0] d, input bit track,
                      input logic [7:0] exp_rsp, output int acc_cyc);
    bit acc = 1'b0;
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=0 for %0d cycles, required 1", n);
    end
    acc_cyc = cyc;
    if (track) begin
      frame_q.push_back({op, d});
      len_q.push_back(op == 2'b11 ? S + 10 + R + 8 : S + 10);
      if (op == 2'b11) rsp_q.push_back(exp_rsp);
    end
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_data = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((frame_q.size() != 0 || rsp_q.size() != 0 || !cmd_ready) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL done_timeout: %0d frames %0d rsps pending, required 0", frame_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ss_n !== 1'b1 || mosi !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: ss_n=%b mosi=%b ready=%b busy=%b rv=%b rd=%h, required 1 0 1 0 0 00",
               ss_n, mosi, cmd_ready, busy, rsp_valid, rsp_data);
    end
`ifdef SPI_RAM_MASTER_STATS_EN
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt);
    end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_address();
    int a;
    send(2'b00, 8'h3C, 1'b1, 8'h00, a);
    wait_done();
  endtask

  task automatic test_write_sequence();
    int a;
    send(2'b00, 8'h05, 1'b1, 8'h00, a);
    send(2'b01, 8'hA5, 1'b1, 8'h00, a);
    wait_done();
    checks++;
    if (ram[5] !== 8'hA5) begin
      errors++;
      $display("FAIL ram_write: RAM[5]=%h, required a5", ram[5]);
    end
  endtask

  task automatic test_read_back();
    int a;
    send(2'b10, 8'h05, 1'b1, 8'h00, a);
    send(2'b11, 8'h00, 1'b1, 8'hA5, a);
    wait_done();
    checks++;
    if (rsp_data !== 8'hA5) begin
      errors++;
      $display("FAIL rsp_hold: rsp_data=%h, required a5", rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    int a[4];
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] dat [4] = '{8'h81, 8'h7E, 8'h81, 8'h00};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], dat[i], 1'b1, 8'h7E, a[i]);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (a[i] - a[i-1] != S + 10 + E + 1) begin
        errors++;
        $display("FAIL accept_spacing: %0d cycles between accepts %0d/%0d, required %0d",
                 a[i] - a[i-1], i - 1, i, S + 10 + E + 1);
      end
    end
    wait_done();
    checks++;
    if (rsp_data !== 8'h7E) begin
      errors++;
      $display("FAIL b2b_rsp: rsp_data=%h, required 7e", rsp_data);
    end
  endtask

  task automatic test_reset_abort();
    int a;
    bit seen = 1'b0;
    send(2'b11, 8'h00, 1'b0, 8'h00, a);
    repeat (S + 4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ss_n !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_data !== 8'h00 || mosi !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: ss_n=%b busy=%b ready=%b rv=%b rd=%h mosi=%b, required 1 0 1 0 00 0",
               ss_n, busy, cmd_ready, rsp_valid, rsp_data, mosi);
    end
`ifdef SPI_RAM_MASTER_STATS_EN
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL abort_frame_cnt: got %0d, required 0", frame_cnt);
    end
`endif
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || !ss_n) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_quiet: activity after abort=1, required 0");
    end
  endtask

  task automatic test_after_reset();
    int a;
    send(2'b00, 8'hC3, 1'b1, 8'h00, a);
    send(2'b01, 8'h5A, 1'b1, 8'h00, a);
    send(2'b10, 8'hC3, 1'b1, 8'h00, a);
    send(2'b11, 8'hFF, 1'b1, 8'h5A, a);
    wait_done();
    checks++;
    if (rsp_data !== 8'h5A) begin
      errors++;
      $display("FAIL post_reset_rsp: rsp_data=%h, required 5a", rsp_data);
    end
`ifdef SPI_RAM_MASTER_STATS_EN
    checks++;
    if (frame_cnt !== 16'd4) begin
      errors++;
      $display("FAIL frame_cnt: got %0d, required 4", frame_cnt);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_write_address();
    test_write_sequence();
    test_read_back();
    test_back_to_back();
    test_reset_abort();
    test_after_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (frame_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d frames %0d rsps outstanding, required 0", frame_q.size(), rsp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
